md_unit_ctrl: RTL and testbench

- Sequencer for the multiply/divide resource that feeds MDout into the E/M/W pipeline registers.
- Accepts MD ops from the E stage, runs a fixed-latency busy window, and commits results to the HI/LO architectural registers.
- Raises a stall to the hazard logic while an E-stage MD instruction cannot proceed.
- Serves MFHI/MFLO reads combinationally as md_out.

---
 rtl/md_pkg.sv | 16 +
 rtl/md_arith.sv | 27 ++
 rtl/md_unit_ctrl.sv | 74 +++++++
 tb/tb_md_unit_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared op codes, cycle defaults and FSM encoding for the multiply/divide unit.
package md_pkg;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] MD_MFHI  = 4'd7;
  localparam logic [OP_W-1:0] MD_MFLO  = 4'd8;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational MULT/MULTU/DIV/DIVU datapath producing {hi, lo} and a divide-by-zero flag.
module md_arith
  import md_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [31:0]     i_a,
  input  logic [31:0]     i_b,
  output logic [63:0]     o_res,
  output logic            o_div0
);
  logic        w_sdiv;
  logic [63:0] w_smul, w_umul;
  logic [31:0] w_ua, w_ub, w_ubs, w_uq, w_ur, w_q, w_r;
  assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_umul = {32'd0, i_a} * {32'd0, i_b};
  // Signed divide runs on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN
  assign w_sdiv = (i_op == MD_DIV);
  assign w_ua   = (w_sdiv && i_a[31]) ? -i_a : i_a;
  assign w_ub   = (w_sdiv && i_b[31]) ? -i_b : i_b;
  assign w_ubs  = (w_ub == 32'd0) ? 32'd1 : w_ub;
  assign w_uq   = w_ua / w_ubs;
  assign w_ur   = w_ua % w_ubs;
  assign w_q    = (w_sdiv && (i_a[31] ^ i_b[31])) ? -w_uq : w_uq;
  assign w_r    = (w_sdiv && i_a[31]) ? -w_ur : w_ur;
  assign o_div0 = ((i_op == MD_DIV) || (i_op == MD_DIVU)) && (i_b == 32'd0);
  assign o_res  = (i_op == MD_MULT) ? w_smul : (i_op == MD_MULTU) ? w_umul : {w_r, w_q};
endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide sequencer with fixed-latency busy window, HI/LO registers,
// pipeline stall generation and combinational MFHI/MFLO read port.
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            md_valid_E,
  input  logic [OP_W-1:0] md_op_E,
  input  logic [31:0]     rs_E,
  input  logic [31:0]     rt_E,
  output logic            stall_md,
  output logic            busy,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic [31:0]     md_out
);
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_pend_hi, r_pend_lo, r_hi, r_lo;
  logic [63:0] w_res;
  logic        w_div0, w_is_arith, w_is_md, w_accept, w_done, w_is_mult;
  md_arith u_arith (
    .i_op   (md_op_E),
    .i_a    (rs_E),
    .i_b    (rt_E),
    .o_res  (w_res),
    .o_div0 (w_div0)
  );
  assign w_is_arith = (md_op_E >= MD_MULT) && (md_op_E <= MD_DIVU);
  assign w_is_md    = (md_op_E >= MD_MULT) && (md_op_E <= MD_MFLO);
  assign w_is_mult  = (md_op_E == MD_MULT) || (md_op_E == MD_MULTU);
  assign w_accept   = md_valid_E && w_is_arith && (r_state == IDLE);
  assign w_done     = (r_state == BUSY) && (r_cnt == 4'd1);
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? BUSY : w_done ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 4'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      if (w_accept) begin
        r_cnt     <= w_is_mult ? 4'(MULT_CYC) : 4'(DIV_CYC);
        // A zero divisor re-commits the current HI/LO, which cannot change while busy
        r_pend_hi <= w_div0 ? r_hi : w_res[63:32];
        r_pend_lo <= w_div0 ? r_lo : w_res[31:0];
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done)                                            r_hi <= r_pend_hi;
      else if (md_valid_E && !stall_md && md_op_E == MD_MTHI) r_hi <= rs_E;
      if (w_done)                                            r_lo <= r_pend_lo;
      else if (md_valid_E && !stall_md && md_op_E == MD_MTLO) r_lo <= rs_E;
    end
  end
  assign busy     = (r_state == BUSY);
  assign stall_md = md_valid_E && w_is_md && busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_out   = (md_valid_E && md_op_E == MD_MFHI) ? r_hi :
                    (md_valid_E && md_op_E == MD_MFLO) ? r_lo : 32'd0;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: table vectors, hand sequences and randomized traffic checked against a cycle-level reference model.
module tb_md_unit_ctrl;
  logic        clk = 1'b0, reset = 1'b0, md_valid_E = 1'b0;
  logic [3:0]  md_op_E = 4'd0;
  logic [31:0] rs_E = 32'd0, rt_E = 32'd0;
  logic        stall_md, busy;
  logic [31:0] hi, lo, md_out;
  int n_chk = 0, n_pass = 0;
  int          m_rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_div0 = 0;

  md_unit_ctrl dut (
    .clk(clk), .reset(reset), .md_valid_E(md_valid_E), .md_op_E(md_op_E),
    .rs_E(rs_E), .rt_E(rt_E), .stall_md(stall_md), .busy(busy),
    .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) $display("FAIL %s actual=%h required=%h", n, a, e);
    else n_pass++;
  endfunction

  function automatic void model_reset();
    m_rem = 0; m_hi = 0; m_lo = 0; m_div0 = 0;
  endfunction

  // Reference: result computed with 64-bit integer arithmetic, busy tracked as cycles remaining
  function automatic void model_edge();
    longint a, b, q, r;
    logic [63:0] u;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && !m_div0) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (md_valid_E) begin
      a = longint'(signed'(rs_E));
      b = longint'(signed'(rt_E));
      case (md_op_E)
        4'd1: begin u = 64'(a * b); m_phi = u[63:32]; m_plo = u[31:0]; m_div0 = 0; m_rem = 5; end
        4'd2: begin u = {32'd0, rs_E} * {32'd0, rt_E}; m_phi = u[63:32]; m_plo = u[31:0]; m_div0 = 0; m_rem = 5; end
        4'd3: begin
          m_div0 = (rt_E == 0); m_rem = 10;
          if (!m_div0) begin q = a / b; r = a % b; m_plo = q[31:0]; m_phi = r[31:0]; end
        end
        4'd4: begin
          m_div0 = (rt_E == 0); m_rem = 10;
          if (!m_div0) begin m_plo = rs_E / rt_E; m_phi = rs_E % rt_E; end
        end
        4'd5: m_hi = rs_E;
        4'd6: m_lo = rs_E;
        default: ;
      endcase
    end
  endfunction

  task automatic cyc();
    bit mb, ms;
    logic [31:0] mo;
    @(negedge clk);
    mb = (m_rem > 0);
    ms = md_valid_E && md_op_E >= 1 && md_op_E <= 8 && mb;
    mo = (md_valid_E && md_op_E == 7) ? m_hi : (md_valid_E && md_op_E == 8) ? m_lo : 32'd0;
    chk("busy", 32'(busy), 32'(mb));
    chk("stall_md", 32'(stall_md), 32'(ms));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("md_out", md_out, mo);
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic drive(logic v, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    md_valid_E = v; md_op_E = op; rs_E = a; rt_E = b;
  endtask

  typedef struct {
    logic v; logic [3:0] op; logic [31:0] a, b;
    int exp_busy; logic [31:0] exp_hi, exp_lo;
  } vec_t;
  vec_t vt[10];

  initial begin
    int nb;
    vt[0] = '{1, 4'd1, 32'hFFFFFFFF, 32'd2,         5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[1] = '{1, 4'd2, 32'hFFFFFFFF, 32'd2,         5,  32'h00000001, 32'hFFFFFFFE};
    vt[2] = '{1, 4'd3, 32'hFFFFFFF9, 32'd2,         10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{1, 4'd4, 32'hFFFFFFF9, 32'd2,         10, 32'h00000001, 32'h7FFFFFFC};
    vt[4] = '{1, 4'd5, 32'h0000000A, 32'd0,         0,  32'h0000000A, 32'h7FFFFFFC};
    vt[5] = '{1, 4'd6, 32'h0000000B, 32'd0,         0,  32'h0000000A, 32'h0000000B};
    vt[6] = '{1, 4'd3, 32'h00000005, 32'd0,         10, 32'h0000000A, 32'h0000000B};
    vt[7] = '{1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vt[8] = '{1, 4'd9, 32'h00001234, 32'd3,         0,  32'h00000000, 32'h80000000};
    vt[9] = '{0, 4'd5, 32'h00001234, 32'd3,         0,  32'h00000000, 32'h80000000};

    drive(1, 4'd7, 32'd0, 32'd0);
    #3;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_stall", 32'(stall_md), 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_md_out", md_out, 0);
    @(posedge clk); #3; reset = 1'b1;
    model_reset();
    drive(0, 4'd0, 0, 0);
    cyc();

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].v, vt[i].op, vt[i].a, vt[i].b);
      cyc();
      drive(0, 4'd0, 0, 0);
      nb = 0;
      for (int k = 0; k < 14; k++) begin
        if (busy) nb++;
        cyc();
      end
      chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(vt[i].exp_busy));
      chk($sformatf("vec%0d_hi", i), hi, vt[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vt[i].exp_lo);
    end

    drive(1, 4'd1, 32'd3, 32'd7);
    cyc();
    drive(0, 4'd0, 0, 0);
    cyc();
    drive(1, 4'd8, 0, 0);
    #1;
    nb = 0;
    while (stall_md && nb < 20) begin nb++; cyc(); end
    #1;
    chk("mflo_stall_cycles", 32'(nb), 4);
    chk("mflo_after_busy", md_out, 32'd21);
    chk("mflo_stall_low", 32'(stall_md), 0);
    cyc();

    drive(1, 4'd5, 32'h12345678, 0);
    cyc();
    drive(1, 4'd7, 0, 0);
    #1;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", 32'(busy), 0);
    chk("mfhi_out", md_out, 32'h12345678);
    chk("mfhi_stall", 32'(stall_md), 0);
    cyc();

    for (int i = 0; i < 1500; i++) begin
      int s;
      s = $urandom_range(0, 7);
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom,
            (s == 0) ? 32'd0 : (s == 1) ? 32'hFFFFFFFF : (s == 2) ? 32'($urandom_range(1, 9)) : $urandom);
      cyc();
    end

    drive(1, 4'd1, 32'hFFFF0000, 32'h00FF00FF);
    cyc();
    drive(0, 4'd0, 0, 0);
    cyc(); cyc(); cyc();
    drive(1, 4'd8, 0, 0);
    #1;
    chk("pre_reset_busy", 32'(busy), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_stall", 32'(stall_md), 0);
    model_reset();
    drive(0, 4'd0, 0, 0);
    @(negedge clk); #2 reset = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("post_reset_hi", hi, 0);
    chk("post_reset_lo", lo, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
